// File: rtl/round_score_collector_pkg.sv
// Shared definitions for the round score collector and the downstream high-score tracker.
package round_score_collector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    REPORT = 2'd2,
    GUARD  = 2'd3
  } state_t;

  // Widths must match the tracker's newScore and playerID ports.
  localparam int SCORE_W = 4;
  localparam int ID_W    = 3;

endpackage

// File: rtl/round_score_collector_if.sv
// Game-side inputs and tracker-side outputs of the round score collector.
interface round_score_collector_if;
  import round_score_collector_pkg::*;

  logic               round_start;
  logic [ID_W-1:0]    start_id;
  logic               guess_valid;
  logic               guess_correct;
  logic               round_abort;
  logic [ID_W-1:0]    playerID;
  logic [SCORE_W-1:0] newScore;
  logic               enable;
  logic               busy;
  logic [SCORE_W-1:0] live_score;
  logic [1:0]         misses;

  modport master (
    output round_start, start_id, guess_valid, guess_correct, round_abort,
    input  playerID, newScore, enable, busy, live_score, misses
  );

  modport slave (
    input  round_start, start_id, guess_valid, guess_correct, round_abort,
    output playerID, newScore, enable, busy, live_score, misses
  );

endinterface

// File: rtl/round_score_collector_sat_counter.sv
// Up-counter that sticks at MAX; clr wins over inc.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/round_score_collector.sv
// Tallies one player's round, reports the final score with a one-cycle enable,
// then holds off new rounds long enough for the tracker to finish its update.
module round_score_collector
  import round_score_collector_pkg::*;
#(
  parameter int MAX_GUESSES  = 8,
  parameter int MAX_MISSES   = 3,
  parameter int SCORE_MAX    = 7,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  round_score_collector_if.slave  bus
);

  localparam int GCNT_W  = $clog2(MAX_GUESSES + 1);
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [GCNT_W-1:0]  LAST_GUESS = GCNT_W'(MAX_GUESSES - 1);
  localparam logic [1:0]         LAST_MISS  = 2'(MAX_MISSES - 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);

  state_t              state_q,     state_d;
  logic [ID_W-1:0]     player_id_q, player_id_d;
  logic [SCORE_W-1:0]  new_score_q, new_score_d;
  logic [GCNT_W-1:0]   guess_cnt_q, guess_cnt_d;
  logic [GUARD_W-1:0]  guard_q,     guard_d;

  logic                cnt_clr;
  logic                score_inc;
  logic                miss_inc;
  logic [SCORE_W-1:0]  live_score;
  logic [1:0]          misses;
  logic [SCORE_W-1:0]  report_score;

  assign report_score = {1'b0, live_score[SCORE_W-2:0]};

  sat_counter #(.WIDTH(SCORE_W), .MAX(SCORE_MAX)) u_score_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (score_inc),
    .count (live_score)
  );

  sat_counter #(.WIDTH(2), .MAX(MAX_MISSES)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (miss_inc),
    .count (misses)
  );

  always_comb begin
    state_d     = state_q;
    player_id_d = player_id_q;
    new_score_d = new_score_q;
    guess_cnt_d = guess_cnt_q;
    guard_d     = guard_q;
    cnt_clr     = 1'b0;
    score_inc   = 1'b0;
    miss_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.round_start) begin
          player_id_d = bus.start_id;
          guess_cnt_d = '0;
          cnt_clr     = 1'b1;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (bus.guess_valid) begin
          guess_cnt_d = guess_cnt_q + 1'b1;
          score_inc   = bus.guess_correct;
          miss_inc    = !bus.guess_correct;
        end
        // Exit is decided on the post-update counts, so look one step ahead.
        if (bus.round_abort ||
            (bus.guess_valid && (guess_cnt_q == LAST_GUESS)) ||
            (bus.guess_valid && !bus.guess_correct && (misses == LAST_MISS))) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        new_score_d = report_score;
        guard_d     = GUARD_LOAD;
        state_d     = GUARD;
      end
      GUARD: begin
        if (guard_q == '0) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      player_id_q <= '0;
      new_score_q <= '0;
      guess_cnt_q <= '0;
      guard_q     <= '0;
    end else begin
      state_q     <= state_d;
      player_id_q <= player_id_d;
      new_score_q <= new_score_d;
      guess_cnt_q <= guess_cnt_d;
      guard_q     <= guard_d;
    end
  end

  // newScore must already be valid during the enable cycle, so bypass the register in REPORT.
  assign bus.newScore   = (state_q == REPORT) ? report_score : new_score_q;
  assign bus.playerID   = player_id_q;
  assign bus.enable     = (state_q == REPORT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.live_score = live_score;
  assign bus.misses     = misses;

endmodule

// File: tb/tb_round_score_collector.sv
// Directed self-checking bench for round_score_collector with default parameters.
module tb_round_score_collector;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   en_count;

  round_score_collector_if bus ();

  round_score_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.enable === 1'b1) en_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic start_round(input logic [2:0] id);
    bus.start_id    = id;
    bus.round_start = 1'b1;
    tick();
    bus.round_start = 1'b0;
  endtask

  task automatic guess(input logic correct, input logic abort);
    bus.guess_valid   = 1'b1;
    bus.guess_correct = correct;
    bus.round_abort   = abort;
    tick();
    bus.guess_valid   = 1'b0;
    bus.guess_correct = 1'b0;
    bus.round_abort   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b0) break;
      tick();
    end
    check(tag, {7'd0, bus.busy}, 8'd0);
  endtask

  initial begin
    logic [7:0] pattern;
    int         busy_cnt;
    int         en_seen;

    checks            = 0;
    failures          = 0;
    en_count          = 0;
    rst               = 1'b1;
    bus.round_start   = 1'b0;
    bus.start_id      = 3'd0;
    bus.guess_valid   = 1'b0;
    bus.guess_correct = 1'b0;
    bus.round_abort   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy",   {7'd0, bus.busy},   8'd0);
    check("rst_enable", {7'd0, bus.enable}, 8'd0);
    check("rst_live",   {4'd0, bus.live_score}, 8'd0);
    check("rst_misses", {6'd0, bus.misses}, 8'd0);
    check("rst_pid",    {5'd0, bus.playerID}, 8'd0);
    check("rst_score",  {4'd0, bus.newScore}, 8'd0);

    // Reset in the middle of a round abandons it without a report.
    start_round(3'd4);
    guess(1'b1, 1'b0);
    guess(1'b1, 1'b0);
    guess(1'b0, 1'b0);
    guess(1'b1, 1'b0);
    check("mid_live",   {4'd0, bus.live_score}, 8'd3);
    check("mid_misses", {6'd0, bus.misses}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstp_busy",   {7'd0, bus.busy}, 8'd0);
    check("rstp_live",   {4'd0, bus.live_score}, 8'd0);
    check("rstp_misses", {6'd0, bus.misses}, 8'd0);
    tick();
    tick();
    check("rstp_no_enable", 8'(en_count), 8'd0);

    // Full round: pattern C C W C C W C C, bit 0 first.
    start_round(3'd5);
    check("full_busy", {7'd0, bus.busy}, 8'd1);
    pattern = 8'b1101_1011;
    for (int i = 0; i < 7; i++) guess(pattern[i], 1'b0);
    check("full_pre_enable", {7'd0, bus.enable}, 8'd0);
    guess(pattern[7], 1'b0);
    check("full_enable", {7'd0, bus.enable}, 8'd1);
    check("full_score",  {4'd0, bus.newScore}, 8'd6);
    check("full_pid",    {5'd0, bus.playerID}, 8'd5);
    check("full_misses", {6'd0, bus.misses}, 8'd2);

    // Guard: starts and guesses during every guard cycle are ignored.
    busy_cnt = 0;
    en_seen  = en_count;
    bus.round_start = 1'b1;
    bus.start_id    = 3'd7;
    bus.guess_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.busy === 1'b1) busy_cnt++;
    end
    bus.round_start = 1'b0;
    bus.guess_valid = 1'b0;
    check("guard_busy_cycles", 8'(busy_cnt), 8'd16);
    check("guard_one_pulse",   8'(en_count - en_seen), 8'd1);
    check("guard_score_hold",  {4'd0, bus.newScore}, 8'd6);
    check("guard_pid_hold",    {5'd0, bus.playerID}, 8'd5);
    check("guard_live_hold",   {4'd0, bus.live_score}, 8'd6);
    tick();
    check("guard_idle", {7'd0, bus.busy}, 8'd0);
    check("guard_pid_after", {5'd0, bus.playerID}, 8'd5);

    // Miss limit, started on the first cycle after busy falls.
    start_round(3'd2);
    check("miss_accept_busy", {7'd0, bus.busy}, 8'd1);
    check("miss_accept_pid",  {5'd0, bus.playerID}, 8'd2);
    check("miss_live_clear",  {4'd0, bus.live_score}, 8'd0);
    guess(1'b1, 1'b0);
    guess(1'b0, 1'b0);
    guess(1'b0, 1'b0);
    check("miss_pre_enable", {7'd0, bus.enable}, 8'd0);
    guess(1'b0, 1'b0);
    check("miss_enable", {7'd0, bus.enable}, 8'd1);
    check("miss_score",  {4'd0, bus.newScore}, 8'd1);
    check("miss_count",  {6'd0, bus.misses}, 8'd3);
    tick();
    check("miss_enable_drop", {7'd0, bus.enable}, 8'd0);
    wait_idle("miss_idle");

    // Saturation: eight correct guesses clamp at seven.
    start_round(3'd6);
    for (int i = 0; i < 7; i++) guess(1'b1, 1'b0);
    check("sat_live7", {4'd0, bus.live_score}, 8'd7);
    guess(1'b1, 1'b0);
    check("sat_live_hold", {4'd0, bus.live_score}, 8'd7);
    check("sat_enable",    {7'd0, bus.enable}, 8'd1);
    check("sat_score",     {4'd0, bus.newScore}, 8'd7);
    wait_idle("sat_idle");

    // Abort together with a correct guess: the guess counts first.
    start_round(3'd1);
    bus.round_start = 1'b1;
    bus.start_id    = 3'd7;
    for (int i = 0; i < 4; i++) guess(1'b1, 1'b0);
    bus.round_start = 1'b0;
    check("play_start_ignored", {5'd0, bus.playerID}, 8'd1);
    check("abort_live4", {4'd0, bus.live_score}, 8'd4);
    guess(1'b1, 1'b1);
    check("abort_enable", {7'd0, bus.enable}, 8'd1);
    check("abort_score",  {4'd0, bus.newScore}, 8'd5);
    wait_idle("abort_idle");

    // Abort on its own reports the partial score.
    start_round(3'd0);
    guess(1'b1, 1'b0);
    guess(1'b0, 1'b0);
    guess(1'b1, 1'b0);
    bus.round_abort = 1'b1;
    tick();
    bus.round_abort = 1'b0;
    check("abort2_enable", {7'd0, bus.enable}, 8'd1);
    check("abort2_score",  {4'd0, bus.newScore}, 8'd2);
    check("abort2_misses", {6'd0, bus.misses}, 8'd1);
    wait_idle("abort2_idle");

    // Guesses and aborts in IDLE leave every counter alone.
    guess(1'b1, 1'b0);
    guess(1'b0, 1'b1);
    guess(1'b1, 1'b0);
    check("idle_busy",   {7'd0, bus.busy}, 8'd0);
    check("idle_live",   {4'd0, bus.live_score}, 8'd2);
    check("idle_misses", {6'd0, bus.misses}, 8'd1);
    start_round(3'd3);
    check("noise_live",   {4'd0, bus.live_score}, 8'd0);
    check("noise_misses", {6'd0, bus.misses}, 8'd0);
    check("noise_pid",    {5'd0, bus.playerID}, 8'd3);
    check("noise_score_hold", {4'd0, bus.newScore}, 8'd2);
    check("total_pulses", 8'(en_count), 8'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_score_collector.md
Name: round_score_collector

Overview:
- Upstream stage of the per-player high-score tracker. Counts correct and missed guesses for one player's round of the memory game.
- Decides when the round ends, then hands the final round score and player ID to the tracker with a one-cycle enable pulse.
- Enforces a guard interval after each report, because the tracker samples enable only in its idle state and takes several cycles per update.

Parameters:
- MAX_GUESSES, 8: guesses per round; the round ends when this count is reached.
- MAX_MISSES, 3: incorrect guesses allowed; the round ends when this count is reached.
- SCORE_MAX, 7: score saturation value; must fit the tracker's 3-bit storage.
- GUARD_CYCLES, 16: idle cycles after each enable pulse before a new round is accepted.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- round_start  in  1  one-cycle pulse that starts a round; honoured only in IDLE
- start_id  in  3  player ID, sampled together with round_start
- guess_valid  in  1  one-cycle pulse: a guess has been resolved
- guess_correct  in  1  result of that guess; valid only when guess_valid=1
- round_abort  in  1  ends the current round early; the partial score is still reported
- playerID  out  3  latched player ID presented to the tracker
- newScore  out  4  final round score; bit 3 is always 0
- enable  out  1  one-cycle report strobe to the tracker
- busy  out  1  high in every state except IDLE
- live_score  out  4  running score for the 7-seg display
- misses  out  2  running miss count

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE; playerID, newScore, live_score, misses, internal guess count and guard counter = 0; enable=0; busy=0.
  - Reset takes priority over every input. Reset in any state abandons the round with no report.
- State machine, states IDLE, PLAY, REPORT, GUARD:
  - IDLE: on round_start=1, latch start_id into playerID, clear live_score, misses and guess count, go to PLAY. All other inputs are ignored.
  - PLAY: on guess_valid=1:
    - guess count +1.
    - If guess_correct=1, live_score +1, saturating at SCORE_MAX.
    - If guess_correct=0, misses +1.
  - PLAY exit: after the update, if guess count == MAX_GUESSES, or misses == MAX_MISSES, or round_abort=1, go to REPORT the next cycle.
  - PLAY, simultaneous events: guess_valid and round_abort in the same cycle means the guess is counted first, then the round ends. round_start is ignored in PLAY.
  - REPORT: lasts exactly one cycle. newScore={1'b0, live_score}; enable=1; load guard counter = GUARD_CYCLES-1; go to GUARD.
  - GUARD: enable=0; decrement the counter. When the counter is 0, go to IDLE. Guesses, aborts and starts are all ignored.
- Latency:
  - Final guess at cycle N → enable high at cycle N+1, with newScore and playerID already valid that cycle.
  - Earliest next round_start accepted at cycle N+2+GUARD_CYCLES.
- Output stability: newScore and playerID hold their values until the next REPORT or reset. enable is high in REPORT only.
- Width rules:
  - live_score never exceeds SCORE_MAX, so the tracker's 3-bit truncation never wraps.
  - The guess counter is clog2(MAX_GUESSES+1) bits.
  - misses never exceeds MAX_MISSES.
- guess_valid in IDLE or GUARD is dropped and does not alter any counter.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=0, PLAY=1, REPORT=2, GUARD=3
  - SCORE_W=4 and ID_W=3, shared with the tracker's newScore and playerID widths
- One natural sub-module: sat_counter (parameterised width and maximum; inc and clr inputs). Instantiate it for live_score and for misses.
- The guard counter stays inline in the top module.

Test Plan:
- Reset: rst=1 mid-PLAY with live_score=3 → next cycle state=IDLE, live_score=0, misses=0, busy=0; no enable pulse at any point.
- Full round: start_id=5; 8 guesses, 6 correct and 2 wrong → one enable pulse the cycle after the 8th guess; newScore=6, playerID=5; busy stays high for 16 further cycles.
- Miss limit: start_id=2; guesses correct, wrong, wrong, wrong → enable the cycle after the 3rd miss; newScore=1, misses=3.
- Saturation and abort:
  - MAX_GUESSES=12 with 10 correct guesses then round_abort → newScore=7.
  - round_abort and a correct guess in the same cycle with live_score=4 → newScore=5.
- Guard interval: round_start asserted on every cycle of GUARD → ignored; the first round_start after busy falls is accepted and latches the new start_id.
- Idle noise: guess_valid pulses in IDLE, then a round_start → the round begins with live_score=0 and misses=0.
